// File: rtl/out_port_pkg.sv
// Shared definitions for the OUT-port capture FIFO: bus width, bus word type
// and a helper that sizes occupancy counters.
package out_port_pkg;

   localparam int BUS_WIDTH = 8;

   typedef logic [BUS_WIDTH-1:0] bus_t;

   // Width needed to hold an occupancy value from 0 up to and including depth.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/out_port_fifo_ptr.sv
// Modulo-DEPTH pointer counter used for the read and write sides of the
// OUT-port FIFO. DEPTH is a power of two, so the pointer wraps naturally.
module fifo_ptr #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     inc,
   output logic [$clog2(DEPTH)-1:0] ptr
);

   localparam int PW = $clog2(DEPTH);

   // Advance the pointer by one slot whenever the owning side moves.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + PW'(1);
      end
   end

endmodule

// File: rtl/out_port_fifo.sv
// Reader end of the 8-bit register write path. Bytes strobed onto the bus with
// enable are buffered in a small FIFO and offered to a slower consumer over a
// valid/ready handshake.
// Optional build macro OUT_PORT_FIFO_BYPASS_EN: when defined, a write into an
// empty FIFO falls through combinationally to out in the same cycle. When not
// defined, out/out_valid come purely from registered state (one-cycle latency).
module out_port_fifo
   import out_port_pkg::*;
#(
   parameter int WIDTH = BUS_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [WIDTH-1:0]          in,
   input  logic                      enable,
   output logic                      full,
   output logic [WIDTH-1:0]          out,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rdPtr;
   logic [PW-1:0]    wrPtr;
   logic             pop;
   logic             pushFifo;
   logic             popFifo;
   logic             notEmpty;

   assign full     = (count == CW'(DEPTH));
   assign notEmpty = (count != '0);

   // Decide what the consumer sees and which side of the FIFO moves this cycle.
   // A dropped write (full, no pop) never touches storage or pointers.
`ifdef OUT_PORT_FIFO_BYPASS_EN
   logic bypassActive;

   always_comb begin
      bypassActive = !notEmpty && enable;
      out_valid    = notEmpty || bypassActive;
      if (bypassActive) begin
         out = in;
      end else if (notEmpty) begin
         out = mem[rdPtr];
      end else begin
         out = '0;
      end
      pop      = out_valid && out_ready;
      popFifo  = pop && !bypassActive;
      pushFifo = enable && (!full || pop) && !(bypassActive && out_ready);
   end
`else
   always_comb begin
      out_valid = notEmpty;
      out       = notEmpty ? mem[rdPtr] : '0;
      pop       = out_valid && out_ready;
      popFifo   = pop;
      pushFifo  = enable && (!full || pop);
   end
`endif

   fifo_ptr #(.DEPTH(DEPTH)) wrPtrInst (
      .clk   (clk),
      .reset (reset),
      .inc   (pushFifo),
      .ptr   (wrPtr)
   );

   fifo_ptr #(.DEPTH(DEPTH)) rdPtrInst (
      .clk   (clk),
      .reset (reset),
      .inc   (popFifo),
      .ptr   (rdPtr)
   );

   // Storage is written only on an accepted push; contents survive reset.
   always_ff @(posedge clk) begin
      if (pushFifo) begin
         mem[wrPtr] <= in;
      end
   end

   // Occupancy tracks pushes minus pops; simultaneous push and pop cancel out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else begin
         case ({pushFifo, popFifo})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky record that a write was lost because the FIFO was full with no pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
      end else if (enable && full && !pop) begin
         overflow <= 1'b1;
      end
   end

endmodule

// File: doc/out_port_fifo.md
Name: out_port_fifo

Overview:
- Reader end of the 8-bit register write path. Captures bytes that the datapath strobes onto the bus using the same in/enable write convention as the register block.
- Buffers captured bytes in a small FIFO and hands them to a downstream consumer (display or serial out) over a valid/ready handshake.
- Sits between the bus and the output peripheral. Decouples instruction-rate OUT writes from a slower consumer.

Parameters:
- WIDTH, 8, data width in bits; matches the bus width.
- DEPTH, 4, number of FIFO entries; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in  input  WIDTH  write data from the bus.
- enable  input  1  write strobe; in is captured on a rising clk edge while enable=1.
- full  output  1  FIFO holds DEPTH entries.
- out  output  WIDTH  head-of-FIFO data.
- out_valid  output  1  out holds a valid byte.
- out_ready  input  1  consumer accepts out this cycle.
- count  output  $clog2(DEPTH+1)  current occupancy.
- overflow  output  1  sticky flag: a write was dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - Read and write pointers cleared to 0.
  - count=0, full=0, out_valid=0, overflow=0, out=0.
  - Storage contents do not need clearing.
  - Reset asserted mid-transfer discards all entries immediately, without waiting for a clock.
- Push condition: push = enable && (!full || pop).
- Pop condition: pop = out_valid && out_ready.
- Push: in is written at the write pointer, which then increments modulo DEPTH (natural wrap, since DEPTH is a power of two).
- Pop: the read pointer increments modulo DEPTH.
- count update:
  - count+1 on push only.
  - count-1 on pop only.
  - Unchanged on simultaneous push and pop, or when neither occurs.
- Flag decoding:
  - full = (count==DEPTH).
  - out_valid = (count!=0) in the default build.
  - Both are decoded from the registered count.
- out is the storage word at the read pointer. It holds stable while out_valid=1 and out_ready=0.
- Latency: a byte written at edge N appears on out with out_valid=1 after edge N (one-cycle write-to-read latency) when the FIFO was empty.
- Full with simultaneous pop: the write is accepted, count stays at DEPTH, no overflow.
- Full without pop while enable=1: the write is dropped, storage is unchanged, and overflow is set to 1. overflow stays set until reset.
- Empty with out_ready=1: no pop; pointers and count unchanged.
- enable held high for K cycles: K consecutive pushes, subject to the full rule. The same byte is captured repeatedly if in is unchanged.
- There is no state machine beyond the pointer/count registers. Storage is a register array written only on push.

Optional Feature:
- Macro: OUT_PORT_FIFO_BYPASS_EN.
- Defined (fall-through): when count==0 and enable=1:
  - out=in and out_valid=1 combinationally in the same cycle.
  - If out_ready=1 that cycle, the byte is consumed directly. No push happens and count stays 0.
  - If out_ready=0, the byte is pushed normally.
  - Zero-cycle latency on an empty FIFO.
- Not defined: strictly registered output with one-cycle latency, as described above. No combinational path from in/enable to out/out_valid.

Decomposition:
- Package out_port_pkg:
  - BUS_WIDTH=8 constant.
  - typedef logic [BUS_WIDTH-1:0] bus_t.
  - function cnt_w(depth), which returns $clog2(depth+1).
- The top module uses the package defaults for WIDTH.
- One natural sub-module: fifo_ptr. It is a modulo-DEPTH pointer counter with an increment input and async active-low reset, instantiated twice (read and write pointers).
- Storage, count and flags stay in out_port_fifo.

Test Plan:
- Reset then idle: reset=0 for 12 time units, release; hold out_ready=1 for 5 cycles -> count=0, out_valid=0, full=0, overflow=0 throughout.
- Single write: in=8'h0F, enable=1 for one cycle, out_ready=0 -> next cycle out=8'h0F, out_valid=1, count=1; raise out_ready for 1 cycle -> count=0, out_valid=0.
- Fill and overflow: write 8'h01..8'h05 on consecutive cycles, out_ready=0 -> count=4, full=1 after the 4th write; 5th write dropped, overflow=1; drain -> 01,02,03,04 in order, overflow still 1.
- Simultaneous push/pop at full: FIFO full with 01..04; enable=1, in=8'hAA, out_ready=1 for one cycle -> count stays 4, overflow stays 0, drain yields 02,03,04,AA.
- Wrap-around: 10 cycles of alternating write/read of 8'h10..8'h19 with DEPTH=4 -> every byte read back once in order; pointers wrap with no loss.
- Async reset mid-operation: 3 bytes queued, pull reset low between clock edges -> count=0, out_valid=0, overflow=0 immediately, before the next clk edge.
